// File: rtl/main_control_unit.sv
// -----------------------------------------------------------------------------
// main_control_unit
//   Multicycle main controller. It steps each instruction through fetch,
//   decode, execute, memory and writeback, and drives every datapath enable,
//   including the 2-bit ALUcontrol code (00 add, 01 sub, 10 use funct).
//   Memory handshakes go through mem_ready.
//
//   Optional feature: define MAIN_CTRL_ADDI_EN to decode OP_ADDI through
//   ADDIEX/ADDIWB. When it is undefined, OP_ADDI is treated as an illegal
//   opcode.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   opcode        IR[31:26], stable from DECODE onward
//   mem_ready     memory finished this cycle (read data valid / write taken)
//   PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUcontrol
//                 datapath controls, decoded from the current state
//   illegal_op    one-cycle pulse when DECODE sees an unknown opcode
//   instr_done    one-cycle pulse in the final state of each instruction
//   state         current state code (debug)
// -----------------------------------------------------------------------------
module main_control_unit #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUcontrol,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    state_t cur;

    // Opcodes that DECODE knows how to dispatch. Everything else raises
    // illegal_op and sends the controller back to FETCH.
    logic legal;
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
`ifdef MAIN_CTRL_ADDI_EN
            OP_ADDI:                              legal = 1'b1;
`endif
            default:                              legal = 1'b0;
        endcase
    end

    // Next-state sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= S_IDLE;
        end else begin
            case (cur)
                S_IDLE:   cur <= S_FETCH;
                S_FETCH:  if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_RTYPE:     cur <= S_EXEC;
                        OP_BEQ:       cur <= S_BRANCH;
                        OP_J:         cur <= S_JUMP;
`ifdef MAIN_CTRL_ADDI_EN
                        OP_ADDI:      cur <= S_ADDIEX;
`else
                        OP_ADDI:      cur <= S_FETCH;  // illegal in this build
`endif
                        default:      cur <= S_FETCH;
                    endcase
                end
                // MEMADR is only reached by LW or SW, so anything not LW is a store.
                S_MEMADR: cur <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
                S_MEMWB:  cur <= S_FETCH;
                S_MEMWR:  if (mem_ready) cur <= S_FETCH;
                S_EXEC:   cur <= S_RWB;
                S_RWB:    cur <= S_FETCH;
                S_BRANCH: cur <= S_FETCH;
                S_JUMP:   cur <= S_FETCH;
`ifdef MAIN_CTRL_ADDI_EN
                S_ADDIEX: cur <= S_ADDIWB;
                S_ADDIWB: cur <= S_FETCH;
`endif
                default:  cur <= S_IDLE;   // unused codes recover to IDLE
            endcase
        end
    end

    // Output decode. The outputs follow the current state, plus the
    // mem_ready handshake in FETCH and MEMWR, so an asynchronous reset
    // drives them all to zero at once.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUcontrol  = 2'b00;
        illegal_op  = 1'b0;
        instr_done  = 1'b0;
        case (cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // PC+4 and IR load commit only in the cycle the read returns.
                PCWrite = mem_ready;
                IRWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;   // branch target precompute
                illegal_op = ~legal;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;  // store completes when accepted
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = 2'b10;
            end
            S_RWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUcontrol  = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
`ifdef MAIN_CTRL_ADDI_EN
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;    // RegDst=0 (rt), MemtoReg=0 (ALUOut)
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign state = cur;

endmodule
